// File: rtl/vga_pkg.sv
// Shared timing defaults, colour constants and enums for the VGA pattern scheduler.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;

  // 12-bit colours packed as {R, G, B}, 4 bits per channel
  localparam logic [11:0] COL_GOLDEN = 12'hF71;
  localparam logic [11:0] COL_SKY    = 12'h3BF;
  localparam logic [11:0] COL_TOMATO = 12'hF11;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_BLACK  = 12'h000;

  typedef enum logic [1:0] {
    PAT_VBARS   = 2'd0,
    PAT_HBARS   = 2'd1,
    PAT_WHITE   = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_SHOW   = 2'd0,
    ST_PEND   = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  function automatic logic [11:0] bar_color(input logic below_b1, input logic below_b2);
    if (below_b1)      return COL_GOLDEN;
    else if (below_b2) return COL_SKY;
    else               return COL_TOMATO;
  endfunction

endpackage

// File: rtl/vga_color_lut.sv
// Combinational map from (pattern, h, v) to a packed 12-bit RGB value; black outside the active area.
module vga_color_lut
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic [1:0]  pattern_id,
  input  logic [10:0] h_pixel,
  input  logic [9:0]  v_pixel,
  output logic [11:0] rgb
);

  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_B1  = 11'(H_ACTIVE / 3);
  localparam logic [10:0] H_B2  = 11'((2 * H_ACTIVE) / 3);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0]  V_B1  = 10'(V_ACTIVE / 3);
  localparam logic [9:0]  V_B2  = 10'((2 * V_ACTIVE) / 3);

  always_comb begin
    rgb = COL_BLACK;
    if ((h_pixel < H_ACT) && (v_pixel < V_ACT)) begin
      case (pattern_id)
        PAT_VBARS:   rgb = bar_color(h_pixel < H_B1, h_pixel < H_B2);
        PAT_HBARS:   rgb = bar_color(v_pixel < V_B1, v_pixel < V_B2);
        PAT_WHITE:   rgb = COL_WHITE;
        PAT_CHECKER: rgb = (h_pixel[5] ^ v_pixel[5]) ? COL_WHITE : COL_BLACK;
        default:     rgb = COL_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Test-pattern scheduler: switches patterns only at frame end on request; registers LUT colour output.
// Optional auto-cycling of patterns every AUTO_FRAMES frames when VGA_AUTO_CYCLE_EN is defined.
module vga_pattern_scheduler
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int AUTO_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_pixel,
  input  logic [9:0]  v_pixel,
  input  logic        next_req,
  output logic        next_ack,
  output logic [1:0]  pattern_id,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  state_e      state_q, state_d;
  pattern_e    pattern_q, pattern_d;
  logic [11:0] rgb_q, rgb_d;
  logic        fe;
  logic        auto_req;

  // Out-of-range counts can never equal the last position, so they never signal frame end
  assign fe = (h_pixel == H_LAST) && (v_pixel == V_LAST);

`ifdef VGA_AUTO_CYCLE_EN
  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_MAX  = FC_W'(AUTO_FRAMES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_SWITCH)
      frame_cnt_d = '0;
    else if (fe && (frame_cnt_q != FC_MAX))
      frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  // This fe is the AUTO_FRAMES-th one counted since the last switch
  assign auto_req = (state_q == ST_SHOW) && fe && (frame_cnt_q >= FC_LAST);
`else
  assign auto_req = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    case (state_q)
      ST_SHOW: begin
        if (fe && (next_req || auto_req)) state_d = ST_SWITCH;
        else if (next_req)                state_d = ST_PEND;
      end
      ST_PEND:   if (fe) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_SHOW;
      default:   state_d = ST_SHOW;
    endcase
    // Advance on entry to SWITCH so the first pixel of the new frame already uses the new pattern
    if ((state_d == ST_SWITCH) && (state_q != ST_SWITCH))
      pattern_d = pattern_e'(pattern_q + 2'd1);
  end

  vga_color_lut #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_lut (
    .pattern_id(pattern_q),
    .h_pixel   (h_pixel),
    .v_pixel   (v_pixel),
    .rgb       (rgb_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SHOW;
      pattern_q <= PAT_VBARS;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      rgb_q     <= rgb_d;
    end
  end

  assign next_ack   = (state_q == ST_SWITCH);
  assign pattern_id = pattern_q;
  assign R          = rgb_q[11:8];
  assign G          = rgb_q[7:4];
  assign B          = rgb_q[3:0];

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Scoreboard bench for vga_pattern_scheduler: stimulus queues expectations, a negedge monitor checks them.
module tb_vga_pattern_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_pixel;
  logic [9:0]  v_pixel;
  logic        next_req;
  logic        next_ack;
  logic [1:0]  pattern_id;
  logic [3:0]  R, G, B;

  always #5 clk = ~clk;

  vga_pattern_scheduler #(
    .H_ACTIVE   (640),
    .V_ACTIVE   (480),
    .H_TOTAL    (800),
    .V_TOTAL    (525),
    .AUTO_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h_pixel   (h_pixel),
    .v_pixel   (v_pixel),
    .next_req  (next_req),
    .next_ack  (next_ack),
    .pattern_id(pattern_id),
    .R         (R),
    .G         (G),
    .B         (B)
  );

  typedef enum int {K_RGB, K_PID, K_ACK} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_RGB:   act = {R, G, B};
          K_PID:   act = {10'd0, pattern_id};
          default: act = {11'd0, next_ack};
        endcase
        checks++;
        if ((sb[i].due < cyc) || (act !== sb[i].val)) begin
          errors++;
          $display("FAIL %s: got %03h expected %03h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int h, input int v, input logic req);
    @(posedge clk);
    #1;
    h_pixel  = 11'(h);
    v_pixel  = 10'(v);
    next_req = req;
  endtask

  task automatic expect_now(input kind_e k, input logic [11:0] val, input string n);
    sb.push_back('{due: cyc, kind: k, val: val, name: n});
  endtask

  task automatic expect_rgb(input logic [11:0] val, input string n);
    sb.push_back('{due: cyc + 1, kind: K_RGB, val: val, name: n});
  endtask

  task automatic frame_end_switch(input logic req, input logic [1:0] pid_after, input logic ack_after,
                                  input string n);
    step(799, 524, req);
    step(0, 0, 1'b0);
    expect_now(K_PID, {10'd0, pid_after}, n);
    expect_now(K_ACK, {11'd0, ack_after}, n);
  endtask

  initial begin
    rst      = 1'b1;
    h_pixel  = '0;
    v_pixel  = '0;
    next_req = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_now(K_RGB, 12'h000, "rst_rgb");
    expect_now(K_PID, 12'd0,   "rst_pid");
    expect_now(K_ACK, 12'd0,   "rst_ack");

    // Pattern 0: vertical bars, first output one clock after release
    step(100, 10, 1'b0); rst = 1'b0; expect_rgb(12'hF71, "p0_bar0");
    step(300, 10, 1'b0); expect_rgb(12'h3BF, "p0_bar1");
    step(500, 10, 1'b0); expect_rgb(12'hF11, "p0_bar2");
    step(700, 10, 1'b0); expect_rgb(12'h000, "p0_hblank");
    step(212, 10, 1'b0); expect_rgb(12'hF71, "p0_h212");
    step(213, 10, 1'b0); expect_rgb(12'h3BF, "p0_h213");
    step(639, 10, 1'b0); expect_rgb(12'hF11, "p0_h639");
    step(100, 480, 1'b0); expect_rgb(12'h000, "p0_vblank");

    // Request mid-frame waits for frame end; second request ignored
    step(5, 5, 1'b1);     expect_now(K_PID, 12'd0, "req_pid_hold0");
    step(6, 5, 1'b1);     expect_now(K_PID, 12'd0, "req_pid_hold1");
    step(1000, 524, 1'b0); expect_now(K_PID, 12'd0, "req_pid_hold2");
    expect_rgb(12'h000, "beyond_rgb");
    step(799, 524, 1'b0); expect_now(K_PID, 12'd0, "req_pid_at_fe");
    expect_now(K_ACK, 12'd0, "req_ack_at_fe");
    step(0, 0, 1'b0);
    expect_now(K_ACK, 12'd1, "req_ack_pulse");
    expect_now(K_PID, 12'd1, "req_pid_new");
    expect_rgb(12'hF71, "p1_first_px");
    step(0, 200, 1'b0);
    expect_now(K_ACK, 12'd0, "req_ack_drop");
    expect_now(K_PID, 12'd1, "req_no_double");
    expect_rgb(12'h3BF, "p1_band1");
    step(0, 400, 1'b0); expect_rgb(12'hF11, "p1_band2");
    step(0, 159, 1'b0); expect_rgb(12'hF71, "p1_v159");
    step(0, 160, 1'b0); expect_rgb(12'h3BF, "p1_v160");

    // Requests in the fe cycle switch at that boundary; walk to wrap
    frame_end_switch(1'b1, 2'd2, 1'b1, "sw_to2");
    expect_rgb(12'hFFF, "p2_white");
    frame_end_switch(1'b1, 2'd3, 1'b1, "sw_to3");
    expect_rgb(12'h000, "p3_origin");
    step(31, 0, 1'b0);  expect_rgb(12'h000, "p3_31_0");
    step(32, 0, 1'b0);  expect_rgb(12'hFFF, "p3_32_0");
    step(32, 32, 1'b0); expect_rgb(12'h000, "p3_32_32");
    step(0, 32, 1'b0);  expect_rgb(12'hFFF, "p3_0_32");
    step(700, 0, 1'b0); expect_rgb(12'h000, "p3_blank");
    frame_end_switch(1'b1, 2'd0, 1'b1, "sw_wrap0");
    expect_rgb(12'hF71, "wrap_p0_px");

    // Mid-frame reset with a request pending
    frame_end_switch(1'b1, 2'd1, 1'b1, "sw_pre_rst");
    step(100, 200, 1'b1);
    #2;
    rst = 1'b1;
    expect_now(K_RGB, 12'h000, "midrst_rgb");
    expect_now(K_PID, 12'd0,   "midrst_pid");
    expect_now(K_ACK, 12'd0,   "midrst_ack");
    step(100, 200, 1'b0); rst = 1'b0; expect_rgb(12'hF71, "postrst_rgb");
    frame_end_switch(1'b0, 2'd0, 1'b0, "pend_dropped");

`ifdef VGA_AUTO_CYCLE_EN
    frame_end_switch(1'b0, 2'd1, 1'b1, "auto_adv1");
    frame_end_switch(1'b0, 2'd1, 1'b0, "auto_hold1");
    frame_end_switch(1'b0, 2'd2, 1'b1, "auto_adv2");
`else
    frame_end_switch(1'b0, 2'd0, 1'b0, "no_auto1");
    frame_end_switch(1'b0, 2'd0, 1'b0, "no_auto2");
    frame_end_switch(1'b0, 2'd0, 1'b0, "no_auto3");
`endif

    repeat (3) step(0, 0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_scheduler.md
VGA_PATTERN_SCHEDULER -- requirements
Module: vga_pattern_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, SHALL set the visible lines per frame.
REQ-003 Parameter H_TOTAL, default 800, SHALL set the pixel clocks per line, blanking included.
REQ-004 Parameter V_TOTAL, default 525, SHALL set the lines per frame, blanking included.
REQ-005 Parameter AUTO_FRAMES, default 60, SHALL set the frames per pattern in auto-cycle mode.
REQ-006 Port clk, input, 1 bit, SHALL be the pixel clock; it is the single clock of the block.
REQ-007 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-008 Port h_pixel, input, 11 bits, SHALL be the current horizontal pixel count from the VGA timing controller.
REQ-009 Port v_pixel, input, 10 bits, SHALL be the current vertical line count from the VGA timing controller.
REQ-010 Port next_req, input, 1 bit, SHALL be the synchronous one-cycle pulse that requests the next pattern.
REQ-011 Port next_ack, output, 1 bit, SHALL pulse for one cycle when a pattern switch takes effect.
REQ-012 Port pattern_id, output, 2 bits, SHALL be the currently displayed pattern.
REQ-013 Ports R, G and B, output, 4 bits each, registered, SHALL carry the colour channels.

Function
REQ-014 The block SHALL support these patterns:
- 0: three vertical bars, split at h<213 / h<426 / h<640:
  - golden yellow R=F G=7 B=1
  - sky blue R=3 G=B B=F
  - tomato R=F G=1 B=1
- 1: the same three colours as horizontal bars, split at v<160 / v<320 / v<480.
- 2: solid white, R=G=B=F.
- 3: 32x32 checkerboard; h[5]^v[5]=1 gives white, otherwise black.
REQ-015 Outside the active area (h_pixel>=H_ACTIVE or v_pixel>=V_ACTIVE), R, G and B SHALL be 0.
REQ-016 The RGB outputs SHALL be registered with a latency of exactly 1 clk from h_pixel/v_pixel.
REQ-017 Frame end (fe) SHALL be the cycle with h_pixel==H_TOTAL-1 and v_pixel==V_TOTAL-1.
REQ-018 The FSM SHALL have the states SHOW, PEND and SWITCH.
REQ-019 In SHOW, next_req=1 without fe SHALL move the FSM to PEND.
REQ-020 In SHOW, next_req=1 with fe in the same cycle SHALL move the FSM directly to SWITCH.
REQ-021 In PEND, fe SHALL move the FSM to SWITCH.
REQ-022 In PEND, further next_req pulses SHALL be ignored (no double advance).
REQ-023 In SWITCH, lasting one cycle:
- pattern_id increments modulo 4 (3 wraps to 0)
- next_ack=1
- the frame counter clears
- the FSM returns to SHOW.
REQ-024 The pattern SHALL only change between frames, never mid-frame; the first pixel of the new frame SHALL use the new pattern.
REQ-025 The frame counter SHALL be ceil(log2(AUTO_FRAMES+1)) bits wide, SHALL increment on each fe, and SHALL saturate at AUTO_FRAMES.
REQ-026 h_pixel/v_pixel values beyond H_TOTAL-1 or V_TOTAL-1 SHALL be treated as blanking, and SHALL never produce fe.

Reset
REQ-027 While rst=1, asynchronously:
- R=G=B=0
- next_ack=0
- pattern_id=0
- state=SHOW
- frame counter=0
- any pending request dropped.
REQ-028 A reset asserted mid-frame SHALL take effect immediately.
REQ-029 After reset release, the first RGB output SHALL appear 1 clk after rst falls.

Configuration
REQ-030 With VGA_AUTO_CYCLE_EN defined, reaching AUTO_FRAMES counted frame ends in SHOW SHALL generate an internal request at that fe, switching as in REQ-020.
REQ-031 With VGA_AUTO_CYCLE_EN defined, next_req SHALL still be honoured, and a manual switch SHALL restart the count.
REQ-032 Without VGA_AUTO_CYCLE_EN, switching SHALL happen only via next_req, and the frame counter logic SHALL be absent.

Structure
REQ-033 Package vga_pkg SHALL hold:
- the timing constants 640/480/800/525
- the colour constants (golden yellow, sky blue, tomato, white, black)
- the 2-bit pattern enum
- the FSM state enum.
REQ-034 A combinational sub-module vga_color_lut SHALL map (pattern_id, h_pixel, v_pixel) to a 12-bit RGB value.
REQ-035 vga_pattern_scheduler SHALL register the output of vga_color_lut and own the FSM and frame counter.

Verification
REQ-036 Reset scenario: rst=1 mid-frame -> RGB=0, pattern_id=0, next_ack=0 in the same cycle.
REQ-037 Pattern 0 scenario: (h,v)=(100,10), (300,10), (500,10), (700,10) -> RGB=F71, 3BF, F11, 000 one clk later.
REQ-038 Request scenario: next_req at (5,5):
- pattern_id stays 0 until fe (799,524)
- next_ack pulses 1 clk after fe
- pattern 1 is shown at (0,0)
- a second next_req at (6,5) does not advance the pattern.
REQ-039 Boundary scenario: next_req in the fe cycle -> switch at that boundary; four switches wrap pattern_id 3 to 0.
REQ-040 Checkerboard scenario: pattern 3 at (31,0) -> black; at (32,0) -> white; at (32,32) -> black.
REQ-041 Auto-cycle scenario, with VGA_AUTO_CYCLE_EN and AUTO_FRAMES=2: the pattern advances every 2 frames with no next_req; without the macro it never advances.
